// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, response codes and SRAM-slave FSM states.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } slv_state_e;

    // Little-endian byte lanes touched by an aligned transfer.
    function automatic logic [3:0] byte_lanes(hsize_e size, logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: byte_lanes = 4'b0001 << addr_lo;
            HSIZE_HALF: byte_lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    byte_lanes = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_sram_bytewe.sv
// Word-organised SRAM with per-byte write enables and asynchronous read; contents are never reset.
module ahb_sram_bytewe #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          HCLK,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [MEM_WORDS];

    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: address-phase capture, legality check, wait-state insertion
// and the two-cycle ERROR response.
//
//  state | meaning
//  IDLE  | no transfer in data phase, zero-wait OKAY
//  WAIT  | legal transfer stalled, HREADYOUT low
//  DATA  | legal transfer completes, write commits / read data driven
//  ERR1  | first ERROR cycle, HREADYOUT low
//  ERR2  | second ERROR cycle, HREADYOUT high
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = AW + 2;

    slv_state_e    state;
    logic [3:0]    wait_cnt;
    logic [BW-1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
    logic          hreadyout_q;
    logic          hresp_q;

    logic          accept;
    logic          legal;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    // Burst type, protection and lock carry no meaning for a plain SRAM.
    logic unused_inputs;
    assign unused_inputs = ^{HTRANS[0], HBURST, HPROT, HMASTLOCK};

    assign accept = HSEL & HREADY & HTRANS[1];

    assign legal = (HSIZE <= 3'd2)
                && !(hsize_e'(HSIZE) == HSIZE_HALF && HADDR[0])
                && !(hsize_e'(HSIZE) == HSIZE_WORD && HADDR[1:0] != 2'b00)
                && (HADDR[31:BW] == '0);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            size_q      <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
        end else begin
            case (state)
                ST_IDLE, ST_DATA, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= HADDR[BW-1:0];
                        write_q <= HWRITE;
                        size_q  <= HSIZE[1:0];
                        if (!legal) begin
                            state       <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_CYCLES > 0) begin
                            state       <= ST_WAIT;
                            wait_cnt    <= 4'(WAIT_CYCLES - 1);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end else begin
                            state       <= ST_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state       <= ST_DATA;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Write commits at the edge closing DATA, so a read pipelined right behind it sees new data.
    assign mem_be = (state == ST_DATA && write_q)
                  ? byte_lanes(hsize_e'({1'b0, size_q}), addr_q[1:0])
                  : 4'b0000;

    ahb_sram_bytewe #(
        .MEM_WORDS (MEM_WORDS)
    ) u_sram (
        .HCLK  (HCLK),
        .addr  (addr_q[BW-1:2]),
        .be    (mem_be),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = (state == ST_DATA && !write_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Two SRAM slaves (0 and 2 wait states) on one AHB-Lite bus, driven by a pipelined master
// and checked every cycle against a transaction-level model.
module tb_ahb_lite_sram_slave;

    localparam int W0 = 0;
    localparam int W1 = 2;
    localparam int NWORDS = 256;

    logic        HCLK;
    logic        HRESETn;
    logic        tgt;
    logic        hsel_en;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        hro0, hro1, hresp0, hresp1;
    logic [31:0] hrdata0, hrdata1;
    logic        owner;
    logic        hready_bus;

    int total = 0;
    int bad   = 0;

    assign hready_bus = owner ? hro1 : hro0;

    ahb_lite_sram_slave #(.MEM_WORDS(NWORDS), .WAIT_CYCLES(W0)) u_s0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_en & ~tgt), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hro0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_lite_sram_slave #(.MEM_WORDS(NWORDS), .WAIT_CYCLES(W1)) u_s1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_en & tgt), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst),
        .HPROT(hprot), .HMASTLOCK(hmastlock), .HWDATA(hwdata), .HREADY(hready_bus),
        .HREADYOUT(hro1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // HREADY mux: the data phase belongs to whichever slave was addressed last accepted cycle.
    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)        owner <= 1'b0;
        else if (hready_bus) owner <= tgt;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        rdy;
        logic        resp;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
    } exp_t;

    exp_t        q [2][$];
    logic [31:0] mem_m [2][NWORDS];
    logic [31:0] last_rd [2];
    logic        last_resp [2];
    int          last_lat [2];
    int          cyc [2];
    bit          pend [2];

    always @(negedge HCLK) begin
        for (int s = 0; s < 2; s++) begin
            exp_t        e;
            logic        r_rdy, r_resp, e_rdy, e_resp, sel_s;
            logic [31:0] r_data, e_data;
            int unsigned a, sz, lane, nwait;
            r_rdy  = (s == 0) ? hro0    : hro1;
            r_resp = (s == 0) ? hresp0  : hresp1;
            r_data = (s == 0) ? hrdata0 : hrdata1;
            e_rdy = 1'b1; e_resp = 1'b0; e_data = 32'h0;
            if (!HRESETn) begin
                q[s].delete();
                pend[s] = 1'b0;
            end else if (q[s].size() > 0) begin
                e = q[s].pop_front();
                e_rdy  = e.rdy;
                e_resp = e.resp;
                if (e.rd) e_data = mem_m[s][e.addr / 4];
                if (e.wr) begin
                    for (int b = 0; b < (1 << e.size); b++) begin
                        lane = (e.addr % 4) + b;
                        mem_m[s][e.addr / 4][lane*8 +: 8] = hwdata[lane*8 +: 8];
                    end
                end
            end
            chk($sformatf("s%0d hreadyout", s), {31'b0, r_rdy},  {31'b0, e_rdy});
            chk($sformatf("s%0d hresp", s),     {31'b0, r_resp}, {31'b0, e_resp});
            chk($sformatf("s%0d hrdata", s),    r_data, e_data);

            if (pend[s]) begin
                cyc[s]++;
                if (r_rdy) begin
                    last_lat[s]  = cyc[s];
                    last_resp[s] = r_resp;
                    last_rd[s]   = r_data;
                    pend[s]      = 1'b0;
                end
            end

            sel_s = hsel_en && (int'(tgt) == s);
            if (HRESETn && sel_s && hready_bus && htrans[1]) begin
                a  = haddr;
                sz = hsize;
                pend[s] = 1'b1;
                cyc[s]  = 0;
                if (sz <= 2 && (a % (1 << sz)) == 0 && a < 4 * NWORDS) begin
                    nwait = (s == 0) ? W0 : W1;
                    repeat (nwait) q[s].push_back('{rdy:1'b0, resp:1'b0, rd:1'b0, wr:1'b0, addr:32'h0, size:3'h0});
                    q[s].push_back('{rdy:1'b1, resp:1'b0, rd:~hwrite, wr:hwrite, addr:a, size:3'(sz)});
                end else begin
                    q[s].push_back('{rdy:1'b0, resp:1'b1, rd:1'b0, wr:1'b0, addr:32'h0, size:3'h0});
                    q[s].push_back('{rdy:1'b1, resp:1'b1, rd:1'b0, wr:1'b0, addr:32'h0, size:3'h0});
                end
            end
        end
    end

    // ---------------- pipelined master ----------------
    task automatic issue(input logic t, input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic rdy;
        int   n;
        tgt       = t;
        hsel_en   = sel;
        htrans    = tr;
        hwrite    = wr;
        hsize     = sz;
        haddr     = a;
        hburst    = 3'($urandom_range(0, 7));
        hprot     = 4'($urandom_range(0, 15));
        hmastlock = 1'($urandom_range(0, 1));
        n = 0;
        while (1) begin
            @(negedge HCLK);
            rdy = hready_bus;
            @(posedge HCLK);
            #1;
            if (rdy) break;
            n++;
            if (n >= 64) begin
                total++;
                bad++;
                $display("FAIL handshake timeout actual=HREADY low required=high within 64 cycles");
                break;
            end
        end
        hwdata = wd;
    endtask

    task automatic idle();
        issue(1'b0, 1'b0, 2'd0, 1'b0, 3'd0, 32'h0, $urandom);
    endtask

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        logic [1:0]  tr;
        int          k;

        tgt = 1'b0; hsel_en = 1'b0; haddr = 32'h0; htrans = 2'd0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; hprot = 4'd0; hmastlock = 1'b0; hwdata = 32'h0;
        HRESETn = 1'b1;
        #1 HRESETn = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        chk("reset s0 hreadyout", {31'b0, hro0},   32'h1);
        chk("reset s0 hresp",     {31'b0, hresp0}, 32'h0);
        chk("reset s0 hrdata",    hrdata0,         32'h0);
        chk("reset s1 hreadyout", {31'b0, hro1},   32'h1);
        chk("reset s1 hresp",     {31'b0, hresp1}, 32'h0);
        chk("reset s1 hrdata",    hrdata1,         32'h0);
        HRESETn = 1'b1;

        // Fill both SRAMs so every later read has a known value.
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < NWORDS; w++)
                issue(1'(s), 1'b1, 2'd2, 1'b1, 3'd2, 32'(w * 4), $urandom);
        idle();

        // Zero-wait word write then read.
        issue(1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h10, $urandom);
        idle();
        chk("s0 word readback", last_rd[0], 32'hDEADBEEF);
        chk("s0 okay latency",  32'(last_lat[0]), 32'd1);

        // Byte and half writes merging into an existing word.
        issue(1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'h11223344);
        issue(1'b0, 1'b1, 2'd2, 1'b1, 3'd0, 32'h13, 32'hAA000000);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h10, $urandom);
        idle();
        chk("s0 byte merge", last_rd[0], 32'hAA223344);
        issue(1'b0, 1'b1, 2'd2, 1'b1, 3'd1, 32'h12, 32'h55660000);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h10, $urandom);
        idle();
        chk("s0 half merge", last_rd[0], 32'h55663344);

        // Two wait states.
        issue(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h0BADF00D);
        issue(1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h40, $urandom);
        idle();
        chk("s1 waited readback", last_rd[1], 32'h0BADF00D);
        chk("s1 okay latency",    32'(last_lat[1]), 32'd3);

        // Illegal transfers: misaligned, out of range, misaligned write.
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h02, $urandom);
        idle();
        chk("err misaligned latency", 32'(last_lat[0]), 32'd2);
        chk("err misaligned resp",    {31'b0, last_resp[0]}, 32'h1);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h400, $urandom);
        idle();
        chk("err range latency", 32'(last_lat[0]), 32'd2);
        chk("err range resp",    {31'b0, last_resp[0]}, 32'h1);
        issue(1'b0, 1'b1, 2'd2, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF);
        issue(1'b0, 1'b1, 2'd2, 1'b0, 3'd2, 32'h10, $urandom);
        idle();
        chk("err write no effect", last_rd[0], 32'h55663344);
        chk("model word 0x10",     mem_m[0][4], 32'h55663344);

        // INCR4 with a BUSY beat between beats 2 and 3.
        issue(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h11110001);
        issue(1'b1, 1'b1, 2'd3, 1'b1, 3'd2, 32'h24, 32'h11110002);
        issue(1'b1, 1'b1, 2'd1, 1'b1, 3'd2, 32'h28, $urandom);
        issue(1'b1, 1'b1, 2'd3, 1'b1, 3'd2, 32'h28, 32'h11110003);
        issue(1'b1, 1'b1, 2'd3, 1'b1, 3'd2, 32'h2C, 32'h11110004);
        issue(1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h20, $urandom);
        issue(1'b1, 1'b1, 2'd3, 1'b0, 3'd2, 32'h24, $urandom);
        issue(1'b1, 1'b1, 2'd1, 1'b0, 3'd2, 32'h28, $urandom);
        issue(1'b1, 1'b1, 2'd3, 1'b0, 3'd2, 32'h28, $urandom);
        issue(1'b1, 1'b1, 2'd3, 1'b0, 3'd2, 32'h2C, $urandom);
        idle();
        chk("burst last beat", last_rd[1], 32'h11110004);
        chk("model burst beat2", mem_m[1][9], 32'h11110002);

        // Reset while a write is stalled in wait states.
        issue(1'b1, 1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'h12345678);
        htrans  = 2'd0;
        hsel_en = 1'b0;
        HRESETn = 1'b0;
        #3;
        chk("midreset s1 hreadyout", {31'b0, hro1},   32'h1);
        chk("midreset s1 hresp",     {31'b0, hresp1}, 32'h0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        issue(1'b1, 1'b1, 2'd2, 1'b0, 3'd2, 32'h40, $urandom);
        idle();
        chk("midreset write dropped", last_rd[1], 32'h0BADF00D);

        // Random traffic across both slaves.
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 9);
            tr = (k == 0) ? 2'd0 : (k == 1) ? 2'd1 : 2'($urandom_range(2, 3));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, 4 * NWORDS - 1));
            if (sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
            k = $urandom_range(0, 19);
            if (k == 0) a = 32'h400 + 32'($urandom_range(0, 255) * 4);
            if (k == 1) a = $urandom;
            issue(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), tr,
                  1'($urandom_range(0, 1)), sz, a, $urandom);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
